gl_primitive_assembly: RTL



---
 rtl/gl_primitive_assembly_pkg.sv | 43 ++++
 rtl/gl_degen_check.sv | 22 ++
 rtl/gl_primitive_assembly.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gl_primitive_assembly_pkg.sv
// Shared types and constants for primitive assembly.
package gl_primitive_assembly_pkg;

  localparam int unsigned VERTEX_TYPE_SIZE = 96;
  localparam int unsigned COORD_W          = 32;
  localparam int unsigned X_MSB            = 95;
  localparam int unsigned X_LSB            = 64;
  localparam int unsigned Y_MSB            = 63;
  localparam int unsigned Y_LSB            = 32;
  localparam int unsigned TRI_COUNT_W      = 32;
  localparam int unsigned CULL_COUNT_W     = 16;

  // Primitive topology; the fourth encoding behaves as plain triangles.
  typedef enum logic [1:0] {
    MODE_TRI     = 2'd0,
    MODE_STRIP   = 2'd1,
    MODE_FAN     = 2'd2,
    MODE_TRI_ALT = 2'd3
  } mode_e;

  // Position of the incoming vertex within the current primitive.
  typedef enum logic [1:0] {
    IDX_0  = 2'd0,
    IDX_1  = 2'd1,
    IDX_2P = 2'd2
  } idx_e;

  // Screen position of a vertex, the only part used for culling.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vtx_xy_t;

  // Collapse the raw mode field onto the three supported topologies.
  function automatic mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_STRIP;
      2'd2:    return MODE_FAN;
      default: return MODE_TRI;
    endcase
  endfunction

endpackage

// File: rtl/gl_degen_check.sv
// Flags a triangle whose vertices share a screen position pairwise.
module gl_degen_check (
  input  logic [63:0] v1_xy,
  input  logic [63:0] v2_xy,
  input  logic [63:0] v3_xy,
  output logic        degen_c
);
  import gl_primitive_assembly_pkg::*;

  vtx_xy_t p1, p2, p3;

  // Any coincident pair collapses the triangle to zero area.
  always_comb begin
    p1      = vtx_xy_t'(v1_xy);
    p2      = vtx_xy_t'(v2_xy);
    p3      = vtx_xy_t'(v3_xy);
    degen_c = ((p1.x == p2.x) && (p1.y == p2.y)) ||
              ((p1.x == p3.x) && (p1.y == p3.y)) ||
              ((p2.x == p3.x) && (p2.y == p3.y));
  end

endmodule

// File: rtl/gl_primitive_assembly.sv
// Assembles a vertex stream into triangles (list, strip, fan) and culls degenerates.
module gl_primitive_assembly #(
  parameter int unsigned VERTEX_TYPE_SIZE = gl_primitive_assembly_pkg::VERTEX_TYPE_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic                        vtx_valid,
  output logic                        vtx_ready,
  input  logic [VERTEX_TYPE_SIZE-1:0] vtx_data,
  input  logic                        vtx_last,
  output logic                        tri_valid,
  input  logic                        tri_ready,
  output logic [VERTEX_TYPE_SIZE-1:0] tri_v1,
  output logic [VERTEX_TYPE_SIZE-1:0] tri_v2,
  output logic [VERTEX_TYPE_SIZE-1:0] tri_v3,
  output logic [31:0]                 tri_count,
  output logic [15:0]                 cull_count
);
  import gl_primitive_assembly_pkg::*;

  idx_e                        idx_q, idx_d;
  mode_e                       mode_q, mode_d;
  logic                        par_q, par_d;
  logic [VERTEX_TYPE_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [VERTEX_TYPE_SIZE-1:0] v1_d, v2_d, v3_d;
  logic [VERTEX_TYPE_SIZE-1:0] c1, c2, c3;
  logic                        valid_d;
  logic [TRI_COUNT_W-1:0]      tri_cnt_d;
  logic [CULL_COUNT_W-1:0]     cull_cnt_d;
  logic                        accept_c, hs_c, cand_c, degen_c;

  // A pending triangle blocks input until it is consumed.
  assign vtx_ready = !tri_valid || tri_ready;
  assign accept_c  = vtx_valid && vtx_ready;
  assign hs_c      = tri_valid && tri_ready;
  assign cand_c    = accept_c && (idx_q == IDX_2P);

  // Odd strip triangles swap the first two vertices to keep winding consistent.
  always_comb begin
    c1 = a_q;
    c2 = b_q;
    c3 = vtx_data;
    if ((mode_q == MODE_STRIP) && par_q) begin
      c1 = b_q;
      c2 = a_q;
    end
  end

  gl_degen_check u_degen (
    .v1_xy   (c1[X_MSB:Y_LSB]),
    .v2_xy   (c2[X_MSB:Y_LSB]),
    .v3_xy   (c3[X_MSB:Y_LSB]),
    .degen_c (degen_c)
  );

  // Next-state for vertex history, output triangle and counters.
  always_comb begin
    idx_d      = idx_q;
    mode_d     = mode_q;
    par_d      = par_q;
    a_d        = a_q;
    b_d        = b_q;
    v1_d       = tri_v1;
    v2_d       = tri_v2;
    v3_d       = tri_v3;
    valid_d    = tri_valid;
    tri_cnt_d  = tri_count;
    cull_cnt_d = cull_count;

    if (hs_c) begin
      valid_d   = 1'b0;
      tri_cnt_d = tri_count + TRI_COUNT_W'(1);
    end

    if (accept_c) begin
      case (idx_q)
        IDX_0: begin
          a_d    = vtx_data;
          idx_d  = IDX_1;
          mode_d = norm_mode(mode);
        end
        IDX_1: begin
          b_d   = vtx_data;
          idx_d = IDX_2P;
        end
        default: begin
          case (mode_q)
            MODE_STRIP: begin
              a_d   = b_q;
              b_d   = vtx_data;
              par_d = !par_q;
            end
            MODE_FAN: b_d = vtx_data;
            default:  idx_d = IDX_0;
          endcase
        end
      endcase
      if (vtx_last) begin
        idx_d = IDX_0;
        par_d = 1'b0;
      end
    end

    if (cand_c) begin
      if (degen_c) begin
        if (cull_count != '1) cull_cnt_d = cull_count + CULL_COUNT_W'(1);
      end else begin
        v1_d    = c1;
        v2_d    = c2;
        v3_d    = c3;
        valid_d = 1'b1;
      end
    end
  end

  // Vertex index state register.
  always_ff @(posedge clk) begin
    if (rst) idx_q <= IDX_0;
    else     idx_q <= idx_d;
  end

  // Datapath and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_TRI;
      par_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tri_v1     <= '0;
      tri_v2     <= '0;
      tri_v3     <= '0;
      tri_valid  <= 1'b0;
      tri_count  <= '0;
      cull_count <= '0;
    end else begin
      mode_q     <= mode_d;
      par_q      <= par_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tri_v1     <= v1_d;
      tri_v2     <= v2_d;
      tri_v3     <= v3_d;
      tri_valid  <= valid_d;
      tri_count  <= tri_cnt_d;
      cull_count <= cull_cnt_d;
    end
  end

endmodule
